// File: rtl/alion_mem_responder.sv
// Wait-state memory responder for a valid/ready core bus, with byte-lane writes.
// Define ALION_MEM_ERR_EN to add the mem_err port and the out-of-range address check.
module alion_mem_lane #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);
  // One byte lane of the word array; holds its contents across reset.
  logic [7:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

module alion_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
`ifdef ALION_MEM_ERR_EN
  output logic [31:0] mem_rdata,
  output logic        mem_err
`else
  output logic [31:0] mem_rdata
`endif
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic              instr;
    logic              oor;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
  } req_t;

  state_t                          state;
  req_t                            req;
  logic [3:0]                      cnt;
  logic                            err_q;
  logic                            oor_d;
  logic                            do_wr;
  logic [NUM_LANES-1:0]            lane_we;
  logic [NUM_LANES-1:0][7:0]       rd_word;
  logic                            unused;

`ifdef ALION_MEM_ERR_EN
  assign oor_d   = (mem_addr >> (ADDR_W + 2)) != 32'd0;
  assign mem_err = err_q;
  assign unused  = ^mem_addr[1:0];
`else
  assign oor_d   = 1'b0;
  assign unused  = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0], err_q};
`endif

  // Instruction fetches and out-of-range requests never modify memory.
  assign do_wr = (state == RESP) && (req.wstrb != 4'd0) && !req.instr && !req.oor;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_we[i] = do_wr && req.wstrb[i];
    alion_mem_lane #(.ADDR_W(ADDR_W)) u_lane (
      .clk   (clk),
      .we    (lane_we[i]),
      .idx   (req.idx),
      .wdata (req.wdata[8*i +: 8]),
      .rdata (rd_word[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req       <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      err_q     <= 1'b0;
      case (state)
        IDLE: if (mem_valid) begin
          req.instr <= mem_instr;
          req.oor   <= oor_d;
          req.idx   <= mem_addr[ADDR_W+1:2];
          req.wdata <= mem_wdata;
          req.wstrb <= mem_wstrb;
          cnt       <= 4'(WAIT_CYCLES);
          state     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
        WAIT: begin
          // A core that drops valid mid-wait has withdrawn the request.
          if (!mem_valid) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt == 4'd1) begin
            state <= RESP;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          mem_ready <= 1'b1;
          state     <= IDLE;
          if (req.oor) begin
            mem_rdata <= 32'h0;
            err_q     <= 1'b1;
          end else if (!(req.wstrb != 4'd0 && !req.instr)) begin
            mem_rdata <= rd_word;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alion_mem_responder.sv
// Randomized bench for alion_mem_responder: one instance with 2 wait states, one with none,
// both checked against a word-array model of the bus.
module tb_alion_mem_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid [2];
  logic        instr [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  logic        ready [2];
  logic [31:0] rdata [2];
  logic        err   [2];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int ready_cyc;

  logic [31:0] mdl  [2][1024];
  logic [31:0] last [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alion_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .mem_valid(valid[0]), .mem_instr(instr[0]),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]),
    .mem_ready(ready[0]),
`ifdef ALION_MEM_ERR_EN
    .mem_rdata(rdata[0]), .mem_err(err[0])
`else
    .mem_rdata(rdata[0])
`endif
  );

  alion_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_valid(valid[1]), .mem_instr(instr[1]),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]),
    .mem_ready(ready[1]),
`ifdef ALION_MEM_ERR_EN
    .mem_rdata(rdata[1]), .mem_err(err[1])
`else
    .mem_rdata(rdata[1])
`endif
  );

`ifndef ALION_MEM_ERR_EN
  initial begin err[0] = 1'b0; err[1] = 1'b0; end
`endif

  function automatic int wc(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present one request and hold it until mem_ready is seen; returns just after that edge.
  task automatic req(input int u, input logic ins, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st, output logic [31:0] rd, output int lat, output logic er);
    valid[u] = 1'b1; instr[u] = ins; addr[u] = a; wdata[u] = wd; wstrb[u] = st;
    @(posedge clk);
    lat = 0;
    forever begin
      @(posedge clk); lat++; #1;
      if (ready[u]) break;
      if (lat > 40) begin
        chk("timeout", 32'(lat), 32'(wc(u) + 1));
        break;
      end
    end
    rd = rdata[u]; er = err[u];
    ready_cyc = cyc;
    valid[u] = 1'b0;
  endtask

  task automatic op(input int u, input logic ins, input logic [31:0] a, input logic [31:0] wd,
                    input logic [3:0] st, input string tag, output logic [31:0] got);
    logic [31:0] ex, rd;
    logic exerr, er;
    bit wr;
    int idx, lat;
    idx = int'((a >> 2) % 1024);
    exerr = 1'b0;
`ifdef ALION_MEM_ERR_EN
    exerr = (a >> 12) != 0;
`endif
    wr = (st != 4'd0) && !ins && !exerr;
    if (exerr)   ex = 32'h0;
    else if (wr) ex = last[u];
    else         ex = mdl[u][idx];
    req(u, ins, a, wd, st, rd, lat, er);
    chk({tag, "_lat"}, 32'(lat), 32'(wc(u) + 1));
    chk({tag, "_rdata"}, rd, ex);
`ifdef ALION_MEM_ERR_EN
    chk({tag, "_err"}, 32'(er), 32'(exerr));
`endif
    if (wr)
      for (int b = 0; b < 4; b++)
        if (st[b]) mdl[u][idx][8*b +: 8] = wd[8*b +: 8];
    last[u] = ex;
    got = rd;
  endtask

  task automatic gap(input int u);
    @(posedge clk); #1;
    chk("rdy_pulse", 32'(ready[u]), 32'd0);
  endtask

  initial begin
    logic [31:0] got, a;
    int c1, seen, u;
    logic ins;
    logic [3:0] st;

    for (int k = 0; k < 2; k++) begin
      valid[k] = 0; instr[k] = 0; addr[k] = 0; wdata[k] = 0; wstrb[k] = 0; last[k] = 0;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", 32'(ready[k]), 32'd0);
      chk("rst_rdata", rdata[k], 32'h0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 64; i++) begin
        op(k, 1'b0, 32'(i * 4), $urandom, 4'hF, "init", got);
        if (i % 8 == 0) gap(k);
      end
    gap(1);

    op(0, 1'b0, 32'h10, 32'h1234_5678, 4'hF, "wr10", got);
    gap(0);
    op(0, 1'b0, 32'h10, 32'h0, 4'h0, "rd10", got);
    chk("rd10_val", got, 32'h1234_5678);
    gap(0);

    op(0, 1'b0, 32'h20, 32'hAABB_CCDD, 4'hF, "wr20", got);
    op(0, 1'b0, 32'h20, 32'h1122_3344, 4'b0101, "wr20s", got);
    op(0, 1'b0, 32'h20, 32'h0, 4'h0, "rd20", got);
    chk("rd20_val", got, 32'hAA22_CC44);
    gap(0);

    op(1, 1'b0, 32'h10, 32'h0, 4'h0, "b2b_a", got);
    c1 = ready_cyc;
    op(1, 1'b0, 32'h20, 32'h0, 4'h0, "b2b_b", got);
    chk("b2b_period", 32'(ready_cyc - c1), 32'd2);
    gap(1);

    op(1, 1'b1, 32'h24, 32'hFFFF_FFFF, 4'hF, "ifetch", got);
    op(1, 1'b0, 32'h24, 32'h0, 4'h0, "ifetch_rd", got);
    gap(1);

    // Write to 0x30 withdrawn after one wait cycle.
    valid[0] = 1; instr[0] = 0; addr[0] = 32'h30; wdata[0] = 32'hDEAD_BEEF; wstrb[0] = 4'hF;
    @(posedge clk); @(posedge clk); #1;
    valid[0] = 0;
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (ready[0]) seen++; end
    chk("abort_rdy", 32'(seen), 32'd0);
    op(0, 1'b0, 32'h30, 32'h0, 4'h0, "abort_rd", got);
    gap(0);

    // Reset while a response pulse is high.
    op(1, 1'b0, 32'h10, 32'h0, 4'h0, "pre_rst1", got);
    rst_n = 1'b0; #1;
    chk("arst_ready", 32'(ready[1]), 32'd0);
    chk("arst_rdata", rdata[1], 32'h0);
    last[0] = 0; last[1] = 0;
    @(negedge clk) rst_n = 1'b1;

    // Reset in the middle of a pending write.
    op(0, 1'b0, 32'h10, 32'h0, 4'h0, "pre_rst0", got);
    valid[0] = 1; instr[0] = 0; addr[0] = 32'h40; wdata[0] = 32'h5A5A_5A5A; wstrb[0] = 4'hF;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("wrst_ready", 32'(ready[0]), 32'd0);
    chk("wrst_rdata", rdata[0], 32'h0);
    valid[0] = 0;
    last[0] = 0; last[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    op(0, 1'b0, 32'h40, 32'h0, 4'h0, "wrst_rd40", got);
    op(0, 1'b0, 32'h10, 32'h0, 4'h0, "wrst_rd10", got);
    chk("retain10", got, 32'h1234_5678);
    gap(0);

    op(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, "hi_addr", got);
    gap(0);

    repeat (400) begin
      u = $urandom_range(0, 1);
      a = 32'($urandom_range(0, 63) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 20'hFFFFF) << 12);
      ins = ($urandom_range(0, 3) == 0);
      st  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      op(u, ins, a, $urandom, st, "rnd", got);
      if ($urandom_range(0, 1) == 0) gap(u);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
